// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP_WORD    = 16'h0800;
    localparam logic [4:0]         HALT_OPCODE = 5'b00000;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD,
        HALTED
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: 5] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: synchronous reset to RESET_PC, loads d when en is high.
module fetch_unit_pc_reg #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_PC;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues reads at PC, buffers a word across decode stalls,
// handles redirects (flush + refetch) and stops after delivering a HALT.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC  = 16'h0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_WORD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [INSTR_W-1:0] redirectPC,
    output logic               imemReq,
    output logic [INSTR_W-1:0] imemAddr,
    input  logic [INSTR_W-1:0] imemRdata,
    input  logic               imemDone,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] pcPlus2,
    output logic               instrValid,
    output logic               halted,
    output fetch_state_e       dbg_state
);

    // Memory handshake: imemReq stays high with imemAddr stable until imemDone; every
    // request the memory has seen is answered by exactly one imemDone pulse.
    fetch_state_e       state;
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] pc_inc;
    logic [INSTR_W-1:0] pc_next;
    logic [INSTR_W-1:0] buf_q;
    logic [INSTR_W-1:0] word;
    logic               drop_q;
    logic               in_fetch;
    logic               mem_done;
    logic               deliver;
    logic               pc_en;

    assign in_fetch  = (state == FETCH) || (state == WAIT);
    assign mem_done  = in_fetch && imemDone && !drop_q;
    assign word      = (state == HOLD) ? buf_q : imemRdata;
    assign deliver   = !redirect && !stall && (mem_done || (state == HOLD));
    assign pc_inc    = pc + 16'd2;
    assign pc_en     = redirect || deliver;
    assign pc_next   = redirect ? redirectPC : pc_inc;
    assign imemReq   = !rst && in_fetch;
    assign imemAddr  = pc;
    assign dbg_state = state;

    fetch_unit_pc_reg #(.RESET_PC(RESET_PC)) pc_reg (
        .clk (clk),
        .rst (rst),
        .en  (pc_en),
        .d   (pc_next),
        .q   (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            instr      <= NOP_INSTR;
            pcPlus2    <= 16'h0000;
            instrValid <= 1'b0;
            halted     <= 1'b0;
            buf_q      <= '0;
            drop_q     <= 1'b0;
        end else if (redirect) begin
            state      <= FETCH;
            instr      <= NOP_INSTR;
            instrValid <= 1'b0;
            halted     <= 1'b0;
            buf_q      <= '0;
            // A request still outstanding at redirect will answer later; remember to drop it.
            drop_q     <= in_fetch && (drop_q || !imemDone);
        end else begin
            if (deliver) begin
                instr      <= word;
                pcPlus2    <= pc_inc;
                instrValid <= 1'b1;
                if (is_halt(word)) begin
                    halted <= 1'b1;
                    state  <= HALTED;
                end else begin
                    state  <= FETCH;
                end
            end else if (!stall && (state != HALTED)) begin
                instr      <= NOP_INSTR;
                instrValid <= 1'b0;
            end

            case (state)
                FETCH, WAIT: begin
                    if (imemDone && drop_q) begin
                        drop_q <= 1'b0;
                        state  <= WAIT;
                    end else if (imemDone && stall) begin
                        buf_q <= imemRdata;
                        state <= HOLD;
                    end else if (!imemDone) begin
                        state <= WAIT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for the main flow plus hand-written
// sequences for redirect, HALT, PC wrap and reset-over-stall corner cases.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic         redirect;
  logic [15:0]  redirectPC;
  logic         imemReq;
  logic [15:0]  imemAddr;
  logic [15:0]  imemRdata;
  logic         imemDone;
  logic [15:0]  instr;
  logic [15:0]  pcPlus2;
  logic         instrValid;
  logic         halted;
  fetch_state_e dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirectPC (redirectPC),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemRdata  (imemRdata),
    .imemDone   (imemDone),
    .instr      (instr),
    .pcPlus2    (pcPlus2),
    .instrValid (instrValid),
    .halted     (halted),
    .dbg_state  (dbg_state)
  );

  // One row = inputs held for one cycle, and the outputs expected during that cycle.
  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        done;
    logic [15:0] rdata;
    logic        req;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        valid;
    logic        halted;
  } vec_t;

  localparam int N_VEC = 21;
  vec_t vecs[N_VEC];

  task automatic cmp16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // driver: apply inputs just after the rising edge
  task automatic cyc(input logic r, input logic s, input logic rd, input logic [15:0] rpc,
                     input logic d, input logic [15:0] data);
    @(posedge clk);
    #1;
    rst        = r;
    stall      = s;
    redirect   = rd;
    redirectPC = rpc;
    imemDone   = d;
    imemRdata  = data;
  endtask

  // sample outputs on the falling edge
  task automatic chk(input string tag, input logic req, input logic [15:0] addr,
                     input logic [15:0] ins, input logic [15:0] pc2, input logic v,
                     input logic h);
    @(negedge clk);
    cmp1 ($sformatf("%s.imemReq", tag), imemReq, req);
    cmp16($sformatf("%s.imemAddr", tag), imemAddr, addr);
    cmp16($sformatf("%s.instr", tag), instr, ins);
    cmp16($sformatf("%s.pcPlus2", tag), pcPlus2, pc2);
    cmp1 ($sformatf("%s.instrValid", tag), instrValid, v);
    cmp1 ($sformatf("%s.halted", tag), halted, h);
  endtask

  initial begin
    rst        = 1'b1;
    stall      = 1'b0;
    redirect   = 1'b0;
    redirectPC = 16'h0000;
    imemDone   = 1'b0;
    imemRdata  = 16'h0000;

    //            rst   stall redir rpc       done  rdata      req   addr      instr     pc2       v     h
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4000, 1'b1, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h4000, 16'h0002, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4020, 1'b1, 16'h0002, 16'h0800, 16'h0002, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h4020, 16'h0004, 1'b1, 1'b0};
    // memory answers three cycles late: address must stay put
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0800, 16'h0004, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0800, 16'h0004, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0800, 16'h0004, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1, 16'h0004, 16'h0800, 16'h0004, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'h1234, 16'h0006, 1'b1, 1'b0};
    // stalled completion goes to the buffer; a done pulse in HOLD is ignored
    vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b1, 16'h0006, 16'h0800, 16'h0006, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0006, 16'h0800, 16'h0006, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hDEAD, 1'b0, 16'h0006, 16'h0800, 16'h0006, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0006, 16'h0800, 16'h0006, 1'b0, 1'b0};
    // stall holds a valid instruction while the next word is buffered
    vecs[15] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0008, 16'h2222, 16'h0008, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h3333, 1'b1, 16'h0008, 16'h2222, 16'h0008, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0008, 16'h2222, 16'h0008, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0008, 16'h2222, 16'h0008, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h000A, 16'h3333, 16'h000A, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h000A, 16'h0800, 16'h000A, 1'b0, 1'b0};

    for (int i = 0; i < N_VEC; i++) begin
      cyc(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].done, vecs[i].rdata);
      chk($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].instr, vecs[i].pc2,
          vecs[i].valid, vecs[i].halted);
    end

    // redirect during WAIT while a valid instruction is held by stall; late data dropped
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555); chk("A1", 1'b1, 16'h000A, 16'h0800, 16'h000A, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000); chk("A2", 1'b1, 16'h000C, 16'h5555, 16'h000C, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0000); chk("A3", 1'b1, 16'h000C, 16'h5555, 16'h000C, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF); chk("A4", 1'b1, 16'h0100, 16'h0800, 16'h000C, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444); chk("A5", 1'b1, 16'h0100, 16'h0800, 16'h000C, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000); chk("A6", 1'b1, 16'h0102, 16'h4444, 16'h0102, 1'b1, 1'b0);

    // HALT stops fetching until a redirect resumes at 0x0040
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000); chk("B1", 1'b1, 16'h0102, 16'h0800, 16'h0102, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000); chk("B2", 1'b0, 16'h0104, 16'h0000, 16'h0104, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777); chk("B3", 1'b0, 16'h0104, 16'h0000, 16'h0104, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000); chk("B4", 1'b0, 16'h0104, 16'h0000, 16'h0104, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000); chk("B5", 1'b1, 16'h0040, 16'h0800, 16'h0104, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h6000); chk("B6", 1'b1, 16'h0040, 16'h0800, 16'h0104, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000); chk("B7", 1'b1, 16'h0042, 16'h6000, 16'h0042, 1'b1, 1'b0);

    // redirect to 0xFFFE beats a same-cycle done; done in FETCH completes at once; PC wraps
    cyc(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b1, 16'h9999); chk("C1", 1'b1, 16'h0042, 16'h0800, 16'h0042, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h6666); chk("C2", 1'b1, 16'hFFFE, 16'h0800, 16'h0042, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000); chk("C3", 1'b1, 16'h0000, 16'h6666, 16'h0000, 1'b1, 1'b0);

    // reset in HOLD wins over redirect and stall and clears the buffered word
    cyc(1'b0, 1'b0, 1'b1, 16'h0300, 1'b0, 16'h0000); chk("D0", 1'b1, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hABCD); chk("D1", 1'b1, 16'h0300, 16'h0800, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1111); chk("D2", 1'b1, 16'h0300, 16'h0800, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000); chk("D3", 1'b0, 16'h0300, 16'h0800, 16'h0000, 1'b0, 1'b0);
    cmp16("D3.state", 16'(dbg_state), 16'(HOLD));
    cyc(1'b1, 1'b1, 1'b1, 16'h0200, 1'b0, 16'h0000); chk("D4", 1'b0, 16'h0300, 16'h0800, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000); chk("D5", 1'b1, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0);
    cmp16("D5.state", 16'(dbg_state), 16'(FETCH));
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4000); chk("D6", 1'b1, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000); chk("D7", 1'b1, 16'h0002, 16'h4000, 16'h0002, 1'b1, 1'b0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
